// File: rtl/snow64_mem_arbiter.sv
// rtl/snow64_mem_arbiter.sv - two-port round-robin arbiter and sequencer for Snow64 main memory
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_p0_req_valid, in_p0_addr   port 0 (instruction fetch) read request
//   out_p0_req_ready              port 0 accept (valid && ready on a rising edge)
//   out_p0_rd_valid/rd_data       port 0 read completion pulse and data
//   in_p1_req_valid, in_p1_req_wr,
//   in_p1_addr, in_p1_wr_data     port 1 (data/LAR) read or write request
//   out_p1_req_ready              port 1 accept
//   out_p1_rd_valid/rd_data       port 1 read completion pulse and data
//   out_p1_wr_done                port 1 write completion pulse
//   out_mem_req_wr/addr/data      memory write-enable, line index, write data
//   in_mem_data                   memory registered (one-cycle latency) read data
module snow64_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  in_p0_req_valid,
  input  logic [ADDR_WIDTH-1:0] in_p0_addr,
  output logic                  out_p0_req_ready,
  output logic                  out_p0_rd_valid,
  output logic [DATA_WIDTH-1:0] out_p0_rd_data,

  input  logic                  in_p1_req_valid,
  input  logic                  in_p1_req_wr,
  input  logic [ADDR_WIDTH-1:0] in_p1_addr,
  input  logic [DATA_WIDTH-1:0] in_p1_wr_data,
  output logic                  out_p1_req_ready,
  output logic                  out_p1_rd_valid,
  output logic                  out_p1_wr_done,
  output logic [DATA_WIDTH-1:0] out_p1_rd_data,

  output logic                  out_mem_req_wr,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  input  logic [DATA_WIDTH-1:0] in_mem_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // port granted most recently; the other port wins a tie
  logic   cur_port;    // port owning the in-flight transaction
  logic   cur_wr;      // in-flight transaction is a write
  logic   p0_win;
  logic   p1_win;

  // Round-robin winner among currently valid requesters.
  always_comb begin
    p0_win = in_p0_req_valid && (!in_p1_req_valid || last_grant);
    p1_win = in_p1_req_valid && (!in_p0_req_valid || !last_grant);
  end

  // Ready is combinational from the valids so a request can be taken the
  // same cycle it appears; it is held low while reset is asserted because
  // the reset edge would discard anything accepted on it.
  assign out_p0_req_ready = !rst && (state == IDLE) && p0_win;
  assign out_p1_req_ready = !rst && (state == IDLE) && p1_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      cur_port        <= 1'b0;
      cur_wr          <= 1'b0;
      out_p0_rd_valid <= 1'b0;
      out_p0_rd_data  <= '0;
      out_p1_rd_valid <= 1'b0;
      out_p1_wr_done  <= 1'b0;
      out_p1_rd_data  <= '0;
      out_mem_req_wr  <= 1'b0;
      out_mem_addr    <= '0;
      out_mem_data    <= '0;
    end else begin
      // Completion strobes are single-cycle pulses.
      out_p0_rd_valid <= 1'b0;
      out_p1_rd_valid <= 1'b0;
      out_p1_wr_done  <= 1'b0;

      case (state)
        IDLE: begin
          if (p0_win) begin
            // Port 0 only reads; write data bus keeps its previous value.
            cur_port       <= 1'b0;
            cur_wr         <= 1'b0;
            out_mem_req_wr <= 1'b0;
            out_mem_addr   <= in_p0_addr;
            last_grant     <= 1'b0;
            state          <= ISSUE;
          end else if (p1_win) begin
            cur_port       <= 1'b1;
            cur_wr         <= in_p1_req_wr;
            out_mem_req_wr <= in_p1_req_wr;
            out_mem_addr   <= in_p1_addr;
            out_mem_data   <= in_p1_wr_data;
            last_grant     <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          // Memory samples address/write-enable on this edge; write-enable
          // must not linger into CAPTURE or the line would be written twice.
          out_mem_req_wr <= 1'b0;
          state          <= CAPTURE;
        end

        CAPTURE: begin
          // in_mem_data now holds the line addressed during ISSUE.
          if (cur_wr) begin
            out_p1_wr_done <= 1'b1;
          end else if (cur_port) begin
            out_p1_rd_valid <= 1'b1;
            out_p1_rd_data  <= in_mem_data;
          end else begin
            out_p0_rd_valid <= 1'b1;
            out_p0_rd_data  <= in_mem_data;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_mem_arbiter.sv
// tb/tb_snow64_mem_arbiter.sv - directed self-checking bench for snow64_mem_arbiter
module tb_snow64_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         p0_valid;
  logic [15:0]  p0_addr;
  logic         p0_ready;
  logic         p0_rd_valid;
  logic [255:0] p0_rd_data;
  logic         p1_valid;
  logic         p1_wr;
  logic [15:0]  p1_addr;
  logic [255:0] p1_wr_data;
  logic         p1_ready;
  logic         p1_rd_valid;
  logic         p1_wr_done;
  logic [255:0] p1_rd_data;
  logic         mem_req_wr;
  logic [15:0]  mem_addr;
  logic [255:0] mem_data;
  logic [255:0] mem_rdata;

  logic [255:0] mem [0:31];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] BEEF = {8{32'hdead_beef}};
  localparam logic [255:0] A5   = {32{8'ha5}};

  always #5 clk = ~clk;

  snow64_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_p0_req_valid  (p0_valid),
    .in_p0_addr       (p0_addr),
    .out_p0_req_ready (p0_ready),
    .out_p0_rd_valid  (p0_rd_valid),
    .out_p0_rd_data   (p0_rd_data),
    .in_p1_req_valid  (p1_valid),
    .in_p1_req_wr     (p1_wr),
    .in_p1_addr       (p1_addr),
    .in_p1_wr_data    (p1_wr_data),
    .out_p1_req_ready (p1_ready),
    .out_p1_rd_valid  (p1_rd_valid),
    .out_p1_wr_done   (p1_wr_done),
    .out_p1_rd_data   (p1_rd_data),
    .out_mem_req_wr   (mem_req_wr),
    .out_mem_addr     (mem_addr),
    .out_mem_data     (mem_data),
    .in_mem_data      (mem_rdata)
  );

  // Memory: no reset, registered read with one-cycle latency.
  always @(posedge clk) begin
    if (mem_req_wr) mem[mem_addr[4:0]] <= mem_data;
    mem_rdata <= mem[mem_addr[4:0]];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a single requester, checked cycle by cycle.
  task automatic txn(input string tag, input int port, input logic wr,
                     input logic [15:0] addr, input logic [255:0] wdata,
                     input logic [255:0] exp_rd);
    if (port == 0) begin
      p0_valid = 1'b1; p0_addr = addr;
    end else begin
      p1_valid = 1'b1; p1_wr = wr; p1_addr = addr; p1_wr_data = wdata;
    end
    #1;
    chk({tag, "_p0_ready"}, p0_ready, (port == 0));
    chk({tag, "_p1_ready"}, p1_ready, (port == 1));
    cyc();                                   // E0: accept
    p0_valid = 1'b0; p1_valid = 1'b0;
    #1;
    chk({tag, "_issue_ready"}, {p0_ready, p1_ready}, 2'b00);
    chk({tag, "_issue_wr"}, mem_req_wr, wr);
    chk({tag, "_issue_addr"}, mem_addr, addr);
    if (wr) chk({tag, "_issue_data"}, mem_data, wdata);
    cyc();                                   // E1: memory samples
    chk({tag, "_capture_wr"}, mem_req_wr, 1'b0);
    chk({tag, "_capture_pulses"}, {p0_rd_valid, p1_rd_valid, p1_wr_done}, 3'b000);
    cyc();                                   // E2: response registered
    chk({tag, "_resp_pulses"}, {p0_rd_valid, p1_rd_valid, p1_wr_done},
        {port == 0, (port == 1) && !wr, (port == 1) && wr});
    chk({tag, "_resp_memwr"}, mem_req_wr, 1'b0);
    if (!wr) chk({tag, "_resp_data"}, (port == 0) ? p0_rd_data : p1_rd_data, exp_rd);
    cyc();
    chk({tag, "_after_pulses"}, {p0_rd_valid, p1_rd_valid, p1_wr_done}, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[1] = 256'd1;
    mem[2] = 256'd2;
    mem[5] = 256'h55;
    rst = 1'b1; p0_valid = 1'b0; p0_addr = '0;
    p1_valid = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wr_data = '0;

    // Reset state.
    cyc(); cyc();
    chk("reset_outputs",
        {p0_ready, p0_rd_valid, p1_ready, p1_rd_valid, p1_wr_done, mem_req_wr}, 6'b0);
    chk("reset_mem_addr", mem_addr, 16'h0);
    chk("reset_mem_data", mem_data, 256'h0);
    chk("reset_p0_rd_data", p0_rd_data, 256'h0);
    chk("reset_p1_rd_data", p1_rd_data, 256'h0);
    rst = 1'b0;
    cyc();

    // Single write then read of the same line.
    txn("t1_wr", 1, 1'b1, 16'h0010, BEEF, '0);
    chk("t1_wr_rd_data_kept", p1_rd_data, 256'h0);
    txn("t1_rd", 0, 1'b0, 16'h0010, '0, BEEF);
    chk("t1_rd_data_held", p0_rd_data, BEEF);

    // Write then read from port 1 with valid held across both requests.
    p1_valid = 1'b1; p1_wr = 1'b1; p1_addr = 16'h0003; p1_wr_data = A5;
    #1;
    chk("t3_wr_ready", p1_ready, 1'b1);
    cyc();                                   // E0 of write
    p1_wr = 1'b0;                            // next request: read same line
    #1;
    chk("t3_issue_ready", p1_ready, 1'b0);
    chk("t3_issue_wr", mem_req_wr, 1'b1);
    cyc(); cyc();                            // E1, E2
    chk("t3_wr_done", p1_wr_done, 1'b1);
    chk("t3_rd_data_unchanged", p1_rd_data, 256'h0);
    chk("t3_rd_ready", p1_ready, 1'b1);
    cyc();                                   // E3: read accepted
    cyc(); cyc();
    chk("t3_rd_valid", p1_rd_valid, 1'b1);
    chk("t3_rd_data", p1_rd_data, A5);
    p1_valid = 1'b0;
    cyc();

    // Both ports hold read requests: grants alternate p0, p1, p0, p1.
    p0_valid = 1'b1; p0_addr = 16'h0001;
    p1_valid = 1'b1; p1_wr = 1'b0; p1_addr = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k > 0) begin
        if ((k % 2) == 1) begin
          chk("t2_p0_rd_valid", p0_rd_valid, 1'b1);
          chk("t2_p0_rd_data", p0_rd_data, 256'd1);
        end else begin
          chk("t2_p1_rd_valid", p1_rd_valid, 1'b1);
          chk("t2_p1_rd_data", p1_rd_data, 256'd2);
        end
      end
      chk("t2_grant", {p0_ready, p1_ready}, ((k % 2) == 0) ? 2'b10 : 2'b01);
      cyc();                                 // accept
      chk("t2_busy_ready", {p0_ready, p1_ready}, 2'b00);
      chk("t2_addr", mem_addr, ((k % 2) == 0) ? 16'h0001 : 16'h0002);
      cyc();
      chk("t2_busy_ready2", {p0_ready, p1_ready}, 2'b00);
      cyc();
    end
    chk("t2_last_p1_rd_valid", p1_rd_valid, 1'b1);
    chk("t2_last_p1_rd_data", p1_rd_data, 256'd2);
    p0_valid = 1'b0; p1_valid = 1'b0;
    cyc();

    // Priority after idle: lone p1 request, then a tie goes to p0.
    txn("t4_p1", 1, 1'b0, 16'h0001, '0, 256'd1);
    p0_valid = 1'b1; p0_addr = 16'h0002;
    p1_valid = 1'b1; p1_wr = 1'b0; p1_addr = 16'h0001;
    #1;
    chk("t4_tie_grant", {p0_ready, p1_ready}, 2'b10);
    p0_valid = 1'b0; p1_valid = 1'b0;
    cyc();

    // Reset during ISSUE of a read.
    p0_valid = 1'b1; p0_addr = 16'h0005;
    cyc();                                   // E0
    p0_valid = 1'b0; rst = 1'b1;
    cyc();                                   // E1 with reset
    rst = 1'b0;
    #1;
    chk("t5_outputs",
        {p0_ready, p0_rd_valid, p1_ready, p1_rd_valid, p1_wr_done, mem_req_wr}, 6'b0);
    chk("t5_mem_addr", mem_addr, 16'h0);
    chk("t5_p0_rd_data", p0_rd_data, 256'h0);
    chk("t5_p1_rd_data", p1_rd_data, 256'h0);
    cyc();
    chk("t5_no_rd_valid_a", p0_rd_valid, 1'b0);
    cyc();
    chk("t5_no_rd_valid_b", p0_rd_valid, 1'b0);
    txn("t5_after", 0, 1'b0, 16'h0005, '0, 256'h55);

    // Reset coincident with E1 of a write: line is committed, no wr_done.
    p1_valid = 1'b1; p1_wr = 1'b1; p1_addr = 16'h0004; p1_wr_data = 256'h1234;
    cyc();                                   // E0
    p1_valid = 1'b0; rst = 1'b1;
    #1;
    chk("t6_issue_wr", mem_req_wr, 1'b1);
    cyc();                                   // E1 with reset
    rst = 1'b0;
    chk("t6_after_reset_wr", mem_req_wr, 1'b0);
    chk("t6_no_done_a", p1_wr_done, 1'b0);
    cyc();
    chk("t6_no_done_b", p1_wr_done, 1'b0);
    cyc();
    chk("t6_no_done_c", p1_wr_done, 1'b0);
    txn("t6_rd", 1, 1'b0, 16'h0004, '0, 256'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snow64_mem_arbiter.md
Name: snow64_mem_arbiter

Overview:
- Two-port request arbiter and sequencer in front of the Snow64 main memory.
- Port 0 is the instruction-fetch side (read-only); port 1 is the data/LAR side (read/write).
- Grants one request at a time with round-robin priority and drives the memory's write-enable, address and write-data.
- Captures the memory's one-cycle-latency registered read data and returns it to the granted port with a single-cycle valid pulse.

Parameters:
- ADDR_WIDTH, 16, width of the memory line index (address counts 256-bit lines, not bytes).
- DATA_WIDTH, 256, width of one memory line.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_p0_req_valid  in  1  port 0 read request.
- in_p0_addr  in  ADDR_WIDTH  port 0 line index.
- out_p0_req_ready  out  1  port 0 request accepted this cycle when ready and valid are both high.
- out_p0_rd_valid  out  1  one-cycle pulse: out_p0_rd_data is new.
- out_p0_rd_data  out  DATA_WIDTH  port 0 read data.
- in_p1_req_valid  in  1  port 1 request.
- in_p1_req_wr  in  1  1 = write, 0 = read.
- in_p1_addr  in  ADDR_WIDTH  port 1 line index.
- in_p1_wr_data  in  DATA_WIDTH  port 1 write data.
- out_p1_req_ready  out  1  port 1 accept, same rule as port 0.
- out_p1_rd_valid  out  1  one-cycle pulse on read completion.
- out_p1_wr_done  out  1  one-cycle pulse on write completion.
- out_p1_rd_data  out  DATA_WIDTH  port 1 read data.
- out_mem_req_wr  out  1  to memory write-enable.
- out_mem_addr  out  ADDR_WIDTH  to memory address.
- out_mem_data  out  DATA_WIDTH  to memory write data.
- in_mem_data  in  DATA_WIDTH  from memory registered read data.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: every output 0. state = IDLE; last_grant = 1, so port 0 wins the first tie.
- States: IDLE, ISSUE, CAPTURE.
- IDLE:
  - winner = the only valid port; if both are valid, winner = !last_grant; if neither, no winner.
  - out_pN_req_ready = (state == IDLE) && (winner == N). This is combinational from the valid inputs; ready never rises outside IDLE.
  - On accept edge E0: latch port id, write flag (port 0 always reads), address and write data into out_mem_*; set last_grant = winner; go to ISSUE.
- ISSUE (one cycle):
  - out_mem_req_wr = latched write flag. It is 0 in every other state.
  - out_mem_addr / out_mem_data are stable.
  - The memory samples on edge E1; go to CAPTURE.
- CAPTURE (one cycle):
  - in_mem_data holds the line at out_mem_addr.
  - On edge E2: read → register in_mem_data into out_pN_rd_data and pulse out_pN_rd_valid for one cycle. Write → pulse out_p1_wr_done and leave rd_data unchanged.
  - Go to IDLE.
- Latency and throughput:
  - Accept to response pulse: 2 cycles. The pulse is visible in the cycle after E2.
  - Next accept is possible at E3, giving at most one request per 3 cycles.
  - Back-to-back requests from the same port alternate fairly with the other port whenever both are valid.
- out_mem_addr and out_mem_data hold their last values in IDLE and CAPTURE. out_mem_req_wr is driven low after E1.
- rd_data holds until that port's next read completes.
- A write followed by a read to the same line returns the written data, because the write commits at E1 of the first transaction.
- Requester rules: a requester must hold valid, addr, wr and data stable until accepted. The arbiter never drops an accepted request except on reset.
- Reset mid-operation: state returns to IDLE and all outputs return to 0 on the reset edge. The in-flight request gets no response.
  - If reset coincides with E1 of a write, the memory still commits that write, because the memory has no reset.
- Widths: no address arithmetic; addresses pass through unmodified, so there is no wrap handling.

Test Plan:
- Reset then single read: port 1 writes line 0x0010 = {8{32'hdead_beef}}; then port 0 reads 0x0010. Required: ready only in IDLE, wr_done 2 cycles after the write accept, p0_rd_valid 2 cycles after the read accept with data {8{32'hdead_beef}}, out_mem_req_wr high exactly 1 cycle.
- Simultaneous requests held: both ports read (p0 0x0001, p1 0x0002, preloaded 1 and 2). Required grant order p0, p1, p0, p1…, with each accept spaced 3 cycles and the correct data per port.
- Write/read ordering: p1 write 0x0003 = 0xa5…a5, then p1 read 0x0003 with valid held continuously. Required: the read returns 0xa5…a5, and out_p1_rd_data is unchanged by the write completion.
- Priority after idle: only p1 requests once (last_grant = 1), then both request together. Required: p0 is granted first.
- Reset in ISSUE of a read: assert rst for 1 cycle during ISSUE. Required: no rd_valid, all outputs 0 the next cycle, state IDLE, and a subsequent request completes normally.
- Reset coincident with E1 of a write to 0x0004 = 0x1234. Required: a later read of 0x0004 returns 0x1234, and no wr_done is seen.
